// File: rtl/point_test_pkg.sv
// Definitions shared by the RX- and TX-side point-test FSMs: sideband message IDs,
// comparator/generator codewords and the point-test state encoding.
package point_test_pkg;

    localparam int unsigned SB_START_REQ       = 1;
    localparam int unsigned SB_START_RESP      = 2;
    localparam int unsigned SB_LFSR_CLR_REQ    = 3;
    localparam int unsigned SB_LFSR_CLR_RESP   = 4;
    localparam int unsigned SB_COUNT_DONE_REQ  = 5;
    localparam int unsigned SB_COUNT_DONE_RESP = 6;
    localparam int unsigned SB_END_REQ         = 7;
    localparam int unsigned SB_END_RESP        = 8;

    localparam logic [1:0] CW_IDLE   = 2'b00;
    localparam logic [1:0] CW_CLEAR  = 2'b01;
    localparam logic [1:0] CW_ACTIVE = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE          = 4'd0,
        ST_WAIT_START    = 4'd1,
        ST_WAIT_LFSR_CLR = 4'd2,
        ST_COMPARE       = 4'd3,
        ST_SETTLE        = 4'd4,
        ST_WAIT_END      = 4'd5,
        ST_FINISHED      = 4'd6
    } pt_state_e;

endpackage

// File: rtl/pt_settle_counter.sv
// Loadable 4-bit down-counter with a zero flag; stops at zero rather than wrapping.
module pt_settle_counter (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [3:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_val;
        end else if (i_dec && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_zero = (count_q == 4'd0);

endmodule

// File: rtl/rx_initiated_point_test_rx.sv
// Responder FSM for the RX-initiated data-to-clock point test: answers the partner's
// sideband requests, sequences the pattern comparator and latches per-lane results.
module rx_initiated_point_test_rx
    import point_test_pkg::*;
#(
    parameter int SB_MSG_WIDTH   = 4,
    parameter int NUM_LANES      = 16,
    parameter int RESULT_LATENCY = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_rx_d2c_pt_en,
    input  logic                    i_datavref_or_valvref,
    input  logic                    i_falling_edge_busy,
    input  logic                    i_rx_msg_valid,
    input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
    input  logic                    i_sb_burst_count,
    input  logic                    i_sb_comparison_mode,
    input  logic [NUM_LANES-1:0]    i_per_lane_error,
    input  logic                    i_valid_lane_error,
    output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_rx,
    output logic                    o_valid_rx,
    output logic [1:0]              o_comparator_cw,
    output logic                    o_val_compare_en,
    output logic                    o_burst_count_cfg,
    output logic                    o_comparison_mode_cfg,
    output logic [NUM_LANES-1:0]    o_lane_result,
    output logic                    o_rx_d2c_pt_done_rx
);

    localparam logic [SB_MSG_WIDTH-1:0] ID_START_REQ   = SB_MSG_WIDTH'(SB_START_REQ);
    localparam logic [SB_MSG_WIDTH-1:0] ID_START_RESP  = SB_MSG_WIDTH'(SB_START_RESP);
    localparam logic [SB_MSG_WIDTH-1:0] ID_LFSR_REQ    = SB_MSG_WIDTH'(SB_LFSR_CLR_REQ);
    localparam logic [SB_MSG_WIDTH-1:0] ID_LFSR_RESP   = SB_MSG_WIDTH'(SB_LFSR_CLR_RESP);
    localparam logic [SB_MSG_WIDTH-1:0] ID_COUNT_REQ   = SB_MSG_WIDTH'(SB_COUNT_DONE_REQ);
    localparam logic [SB_MSG_WIDTH-1:0] ID_COUNT_RESP  = SB_MSG_WIDTH'(SB_COUNT_DONE_RESP);
    localparam logic [SB_MSG_WIDTH-1:0] ID_END_REQ     = SB_MSG_WIDTH'(SB_END_REQ);
    localparam logic [SB_MSG_WIDTH-1:0] ID_END_RESP    = SB_MSG_WIDTH'(SB_END_RESP);
    localparam logic [3:0]              SETTLE_LOAD    = 4'(RESULT_LATENCY - 1);

    pt_state_e                state_q, state_d;
    logic [SB_MSG_WIDTH-1:0]  msg_q, msg_d;
    logic                     valid_q, valid_d;
    logic [1:0]               cw_q, cw_d;
    logic                     val_en_q, val_en_d;
    logic                     burst_q, burst_d;
    logic                     mode_q, mode_d;
    logic [NUM_LANES-1:0]     lane_q, lane_d;
    logic                     done_q, done_d;
    logic                     cnt_load, cnt_dec, cnt_zero;
    logic                     issue;
    logic [SB_MSG_WIDTH-1:0]  issue_id;
    logic                     msg_gone;

    pt_settle_counter u_settle_counter (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (cnt_load),
        .i_load_val (SETTLE_LOAD),
        .i_dec      (cnt_dec),
        .o_zero     (cnt_zero)
    );

    function automatic logic is_req(input logic vld, input logic [SB_MSG_WIDTH-1:0] msg,
                                    input logic [SB_MSG_WIDTH-1:0] id);
        return vld && (msg == id);
    endfunction

    assign msg_gone = i_falling_edge_busy && valid_q;

    always_comb begin
        state_d  = state_q;
        msg_d    = msg_q;
        valid_d  = valid_q;
        cw_d     = cw_q;
        val_en_d = val_en_q;
        burst_d  = burst_q;
        mode_d   = mode_q;
        lane_d   = lane_q;
        done_d   = done_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        issue    = 1'b0;
        issue_id = '0;

        if (msg_gone) valid_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_WAIT_START: begin
                if (i_rx_d2c_pt_en) begin
                    state_d = ST_WAIT_START;
                    if (is_req(i_rx_msg_valid, i_decoded_SB_msg, ID_START_REQ)) begin
                        burst_d  = i_sb_burst_count;
                        mode_d   = i_sb_comparison_mode;
                        issue    = 1'b1;
                        issue_id = ID_START_RESP;
                        state_d  = ST_WAIT_LFSR_CLR;
                    end
                end
            end
            ST_WAIT_LFSR_CLR: begin
                if (is_req(i_rx_msg_valid, i_decoded_SB_msg, ID_LFSR_REQ)) begin
                    if (i_datavref_or_valvref) val_en_d = 1'b1;
                    else                       cw_d     = CW_CLEAR;
                    issue    = 1'b1;
                    issue_id = ID_LFSR_RESP;
                    state_d  = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (is_req(i_rx_msg_valid, i_decoded_SB_msg, ID_COUNT_REQ)) begin
                    cw_d     = CW_IDLE;
                    val_en_d = 1'b0;
                    cnt_load = 1'b1;
                    state_d  = ST_SETTLE;
                end else if (cw_q == CW_CLEAR) begin
                    cw_d = CW_ACTIVE;
                end
            end
            ST_SETTLE: begin
                if (cnt_zero) begin
                    if (i_datavref_or_valvref) begin
                        lane_d    = '0;
                        lane_d[0] = ~i_valid_lane_error;
                    end else if (mode_q) begin
                        lane_d = {NUM_LANES{~|i_per_lane_error}};
                    end else begin
                        lane_d = ~i_per_lane_error;
                    end
                    issue    = 1'b1;
                    issue_id = ID_COUNT_RESP;
                    state_d  = ST_WAIT_END;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_WAIT_END: begin
                if (is_req(i_rx_msg_valid, i_decoded_SB_msg, ID_END_REQ)) begin
                    issue    = 1'b1;
                    issue_id = ID_END_RESP;
                    state_d  = ST_FINISHED;
                end
            end
            ST_FINISHED: begin
                if (msg_gone) done_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (issue) begin
            valid_d = 1'b1;
            msg_d   = issue_id;
        end

        // Dropping enable aborts from any state and clears every output.
        if (!i_rx_d2c_pt_en) begin
            state_d  = ST_IDLE;
            msg_d    = '0;
            valid_d  = 1'b0;
            cw_d     = CW_IDLE;
            val_en_d = 1'b0;
            burst_d  = 1'b0;
            mode_d   = 1'b0;
            lane_d   = '0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            msg_q    <= '0;
            valid_q  <= 1'b0;
            cw_q     <= CW_IDLE;
            val_en_q <= 1'b0;
            burst_q  <= 1'b0;
            mode_q   <= 1'b0;
            lane_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            msg_q    <= msg_d;
            valid_q  <= valid_d;
            cw_q     <= cw_d;
            val_en_q <= val_en_d;
            burst_q  <= burst_d;
            mode_q   <= mode_d;
            lane_q   <= lane_d;
            done_q   <= done_d;
        end
    end

    assign o_encoded_SB_msg_rx   = msg_q;
    assign o_valid_rx            = valid_q;
    assign o_comparator_cw       = cw_q;
    assign o_val_compare_en      = val_en_q;
    assign o_burst_count_cfg     = burst_q;
    assign o_comparison_mode_cfg = mode_q;
    assign o_lane_result         = lane_q;
    assign o_rx_d2c_pt_done_rx   = done_q;

endmodule

// File: tb/tb_rx_initiated_point_test_rx.sv
// Directed bench for the RX-side point-test responder: sideband sequencing, comparator
// control, result snapshot, enable abort and async reset.
module tb_rx_initiated_point_test_rx;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_rx_d2c_pt_en;
    logic        i_datavref_or_valvref;
    logic        i_falling_edge_busy;
    logic        i_rx_msg_valid;
    logic [3:0]  i_decoded_SB_msg;
    logic        i_sb_burst_count;
    logic        i_sb_comparison_mode;
    logic [15:0] i_per_lane_error;
    logic        i_valid_lane_error;
    logic [3:0]  o_encoded_SB_msg_rx;
    logic        o_valid_rx;
    logic [1:0]  o_comparator_cw;
    logic        o_val_compare_en;
    logic        o_burst_count_cfg;
    logic        o_comparison_mode_cfg;
    logic [15:0] o_lane_result;
    logic        o_rx_d2c_pt_done_rx;

    int n_tests = 0;
    int n_fail  = 0;

    rx_initiated_point_test_rx #(
        .SB_MSG_WIDTH   (4),
        .NUM_LANES      (16),
        .RESULT_LATENCY (2)
    ) dut (
        .i_clk                 (i_clk),
        .i_rst_n               (i_rst_n),
        .i_rx_d2c_pt_en        (i_rx_d2c_pt_en),
        .i_datavref_or_valvref (i_datavref_or_valvref),
        .i_falling_edge_busy   (i_falling_edge_busy),
        .i_rx_msg_valid        (i_rx_msg_valid),
        .i_decoded_SB_msg      (i_decoded_SB_msg),
        .i_sb_burst_count      (i_sb_burst_count),
        .i_sb_comparison_mode  (i_sb_comparison_mode),
        .i_per_lane_error      (i_per_lane_error),
        .i_valid_lane_error    (i_valid_lane_error),
        .o_encoded_SB_msg_rx   (o_encoded_SB_msg_rx),
        .o_valid_rx            (o_valid_rx),
        .o_comparator_cw       (o_comparator_cw),
        .o_val_compare_en      (o_val_compare_en),
        .o_burst_count_cfg     (o_burst_count_cfg),
        .o_comparison_mode_cfg (o_comparison_mode_cfg),
        .o_lane_result         (o_lane_result),
        .o_rx_d2c_pt_done_rx   (o_rx_d2c_pt_done_rx)
    );

    always #5 i_clk = ~i_clk;

    logic [26:0] all_outs;
    assign all_outs = {o_encoded_SB_msg_rx, o_valid_rx, o_comparator_cw, o_val_compare_en,
                       o_burst_count_cfg, o_comparison_mode_cfg, o_lane_result,
                       o_rx_d2c_pt_done_rx};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [3:0] id);
        i_rx_msg_valid   = 1'b1;
        i_decoded_SB_msg = id;
        tick();
        i_rx_msg_valid   = 1'b0;
        i_decoded_SB_msg = 4'd0;
    endtask

    task automatic bfall();
        i_falling_edge_busy = 1'b1;
        tick();
        i_falling_edge_busy = 1'b0;
    endtask

    // Full flow from IDLE with enable low; ends with enable low again.
    task automatic run_flow(input string tag, input logic vv, input logic mode,
                            input logic [15:0] errs, input logic verr,
                            input logic [15:0] exp_lane);
        i_datavref_or_valvref = vv;
        i_sb_comparison_mode  = mode;
        i_rx_d2c_pt_en        = 1'b1;
        send(4'd1);
        chk({tag, "_start_resp"}, {27'd0, o_valid_rx, o_encoded_SB_msg_rx}, 32'h12);
        chk({tag, "_mode_cfg"}, {31'd0, o_comparison_mode_cfg}, {31'd0, mode});
        bfall();
        send(4'd3);
        chk({tag, "_clr_cw"}, {30'd0, o_comparator_cw}, vv ? 32'd0 : 32'd1);
        i_falling_edge_busy = 1'b1;
        tick();
        i_falling_edge_busy = 1'b0;
        chk({tag, "_cmp_cw"}, {30'd0, o_comparator_cw}, vv ? 32'd0 : 32'd2);
        chk({tag, "_cmp_val_en"}, {31'd0, o_val_compare_en}, {31'd0, vv});
        i_per_lane_error   = errs;
        i_valid_lane_error = verr;
        send(4'd5);
        chk({tag, "_settle_outs"}, {29'd0, o_valid_rx, o_comparator_cw}, 32'd0);
        tick();
        tick();
        chk({tag, "_count_resp"}, {27'd0, o_valid_rx, o_encoded_SB_msg_rx}, 32'h16);
        chk({tag, "_lane_result"}, {16'd0, o_lane_result}, {16'd0, exp_lane});
        chk({tag, "_val_en_off"}, {31'd0, o_val_compare_en}, 32'd0);
        i_rx_d2c_pt_en = 1'b0;
        tick();
        chk({tag, "_abort_clear"}, {5'd0, all_outs}, 32'd0);
    endtask

    initial begin
        i_rst_n               = 1'b1;
        i_rx_d2c_pt_en        = 1'b0;
        i_datavref_or_valvref = 1'b0;
        i_falling_edge_busy   = 1'b0;
        i_rx_msg_valid        = 1'b0;
        i_decoded_SB_msg      = 4'd0;
        i_sb_burst_count      = 1'b1;
        i_sb_comparison_mode  = 1'b0;
        i_per_lane_error      = 16'h0000;
        i_valid_lane_error    = 1'b0;
        #1 i_rst_n = 1'b0;
        #2;
        chk("reset_outs", {5'd0, all_outs}, 32'd0);
        tick();
        i_rst_n = 1'b1;
        tick();

        // Data-lane per-lane flow
        i_rx_d2c_pt_en = 1'b1;
        tick();
        i_rx_msg_valid   = 1'b0;
        i_decoded_SB_msg = 4'd1;
        tick();
        i_decoded_SB_msg = 4'd0;
        chk("unqualified_start", {31'd0, o_valid_rx}, 32'd0);
        send(4'd1);
        chk("start_resp", {27'd0, o_valid_rx, o_encoded_SB_msg_rx}, 32'h12);
        chk("burst_cfg", {31'd0, o_burst_count_cfg}, 32'd1);
        bfall();
        chk("busy_fall_clears", {31'd0, o_valid_rx}, 32'd0);
        send(4'd7);
        chk("ooo_end_ignored", {29'd0, o_valid_rx, o_comparator_cw}, 32'd0);
        send(4'd3);
        chk("lfsr_resp_clear", {25'd0, o_valid_rx, o_encoded_SB_msg_rx, o_comparator_cw},
            32'h51);
        i_falling_edge_busy = 1'b1;
        tick();
        i_falling_edge_busy = 1'b0;
        chk("cw_active", {29'd0, o_valid_rx, o_comparator_cw}, 32'h2);
        i_per_lane_error = 16'h0005;
        send(4'd5);
        chk("settle_e0", {29'd0, o_valid_rx, o_comparator_cw}, 32'd0);
        tick();
        chk("settle_e1", {31'd0, o_valid_rx}, 32'd0);
        tick();
        chk("count_resp_lat", {27'd0, o_valid_rx, o_encoded_SB_msg_rx}, 32'h16);
        chk("lane_perlane", {16'd0, o_lane_result}, 32'hFFFA);
        bfall();
        send(4'd7);
        chk("end_resp", {27'd0, o_valid_rx, o_encoded_SB_msg_rx}, 32'h18);
        chk("done_before_fall", {31'd0, o_rx_d2c_pt_done_rx}, 32'd0);
        bfall();
        chk("done_after_fall", {30'd0, o_valid_rx, o_rx_d2c_pt_done_rx}, 32'd1);
        tick();
        chk("done_hold", {15'd0, o_rx_d2c_pt_done_rx, o_lane_result}, 32'h1FFFA);
        i_rx_d2c_pt_en = 1'b0;
        tick();
        chk("disable_clear", {5'd0, all_outs}, 32'd0);

        run_flow("agg_err",  1'b0, 1'b1, 16'h0100, 1'b0, 16'h0000);
        run_flow("agg_ok",   1'b0, 1'b1, 16'h0000, 1'b0, 16'hFFFF);
        run_flow("vld_err",  1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000);
        run_flow("vld_ok",   1'b1, 1'b0, 16'hFFFF, 1'b0, 16'h0001);

        // Enable drop in SETTLE
        i_datavref_or_valvref = 1'b0;
        i_sb_comparison_mode  = 1'b0;
        i_per_lane_error      = 16'h0000;
        i_rx_d2c_pt_en        = 1'b1;
        send(4'd1);
        bfall();
        send(4'd3);
        tick();
        send(4'd5);
        i_rx_d2c_pt_en = 1'b0;
        tick();
        chk("drop_settle", {5'd0, all_outs}, 32'd0);
        tick();
        chk("drop_settle_quiet", {5'd0, all_outs}, 32'd0);

        // Enable drop in COMPARE with a response pending
        i_rx_d2c_pt_en = 1'b1;
        send(4'd1);
        bfall();
        send(4'd3);
        chk("pending_lfsr", {27'd0, o_valid_rx, o_encoded_SB_msg_rx}, 32'h14);
        i_rx_d2c_pt_en = 1'b0;
        tick();
        chk("drop_compare", {5'd0, all_outs}, 32'd0);
        i_rx_d2c_pt_en = 1'b1;
        send(4'd1);
        chk("reen_start", {27'd0, o_valid_rx, o_encoded_SB_msg_rx}, 32'h12);
        send(4'd3);
        chk("reen_lfsr", {25'd0, o_valid_rx, o_encoded_SB_msg_rx, o_comparator_cw}, 32'h51);
        tick();
        chk("pre_reset_cw", {30'd0, o_comparator_cw}, 32'd2);

        // Async reset mid-COMPARE
        #2 i_rst_n = 1'b0;
        #1;
        chk("async_reset", {5'd0, all_outs}, 32'd0);
        tick();
        i_rst_n = 1'b1;
        tick();
        send(4'd1);
        chk("resume_start", {27'd0, o_valid_rx, o_encoded_SB_msg_rx}, 32'h12);
        i_rx_d2c_pt_en = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
